// File: rtl/axi_pkg.sv
// Shared AXI4 definitions: burst/response codes, the ami_w FSM state enum and
// the 4KB-boundary check used when AMI_W_4KB_CHECK_EN is defined.
package axi_pkg;

   localparam logic [1:0] BURST_FIXED = 2'b00;
   localparam logic [1:0] BURST_INCR  = 2'b01;
   localparam logic [1:0] BURST_WRAP  = 2'b10;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   typedef enum logic [1:0] {IDLE, XFER, RESP, DRAIN} ami_w_state_e;

   // True when an INCR burst starting at addr_lo would run past the 4KB page.
   function automatic logic crosses_4kb(input logic [11:0] addr_lo,
                                        input logic [15:0] len,
                                        input logic [2:0]  size,
                                        input logic [1:0]  burst);
      logic [31:0] span;
      span = (32'(len) + 32'd1) << size;
      return (burst == BURST_INCR) && ((32'(addr_lo) + span) > 32'd4096);
   endfunction

endpackage

// File: rtl/ami_w.sv
// User-to-AXI4 write master: one outstanding burst, W beats passed straight through.
// Optional macro AMI_W_4KB_CHECK_EN drains (and SLVERRs) INCR bursts crossing 4KB.
module ami_w
   import axi_pkg::*;
#(
   parameter int AXI_DW     = 128,
   parameter int AXI_AW     = 40,
   parameter int AXI_IW     = 8,
   parameter int AXI_LW     = 8,
   parameter int AXI_SW     = 3,
   parameter int AXI_BURSTW = 2,
   parameter int AXI_BRESPW = 2,
   parameter int AXI_WSTRBW = AXI_DW / 8
) (
   input  logic                  ACLK,
   input  logic                  ARESET,

   input  logic                  usr_cmd_valid,
   output logic                  usr_cmd_ready,
   input  logic [AXI_IW-1:0]     usr_cmd_id,
   input  logic [AXI_AW-1:0]     usr_cmd_addr,
   input  logic [AXI_LW-1:0]     usr_cmd_len,
   input  logic [AXI_SW-1:0]     usr_cmd_size,
   input  logic [AXI_BURSTW-1:0] usr_cmd_burst,

   input  logic [AXI_DW-1:0]     usr_wdata,
   input  logic [AXI_WSTRBW-1:0] usr_wstrb,
   input  logic                  usr_wvalid,
   output logic                  usr_wready,

   output logic                  usr_bvalid,
   output logic [AXI_IW-1:0]     usr_bid,
   output logic [AXI_BRESPW-1:0] usr_bresp,

   output logic [AXI_IW-1:0]     AWID,
   output logic [AXI_AW-1:0]     AWADDR,
   output logic [AXI_LW-1:0]     AWLEN,
   output logic [AXI_SW-1:0]     AWSIZE,
   output logic [AXI_BURSTW-1:0] AWBURST,
   output logic                  AWVALID,
   input  logic                  AWREADY,

   output logic [AXI_DW-1:0]     WDATA,
   output logic [AXI_WSTRBW-1:0] WSTRB,
   output logic                  WLAST,
   output logic                  WVALID,
   input  logic                  WREADY,

   input  logic [AXI_IW-1:0]     BID,
   input  logic [AXI_BRESPW-1:0] BRESP,
   input  logic                  BVALID,
   output logic                  BREADY
);

   ami_w_state_e          state, next_state;
   logic [AXI_IW-1:0]     id_q;
   logic [AXI_AW-1:0]     addr_q;
   logic [AXI_LW-1:0]     len_q;
   logic [AXI_SW-1:0]     size_q;
   logic [AXI_BURSTW-1:0] burst_q;
   logic [AXI_LW-1:0]     beat_cnt;
   logic                  aw_done, w_done;
   logic                  cmd_accept, cmd_illegal, last_beat;

   assign usr_cmd_ready = (state == IDLE) && !ARESET;
   assign cmd_accept    = usr_cmd_valid && usr_cmd_ready;
   assign last_beat     = (beat_cnt == len_q);

`ifdef AMI_W_4KB_CHECK_EN
   assign cmd_illegal = crosses_4kb(usr_cmd_addr[11:0], 16'(usr_cmd_len),
                                    3'(usr_cmd_size), 2'(usr_cmd_burst));
`else
   assign cmd_illegal = 1'b0;
`endif

   assign AWID    = id_q;
   assign AWADDR  = addr_q;
   assign AWLEN   = len_q;
   assign AWSIZE  = size_q;
   assign AWBURST = burst_q;
   assign WDATA   = usr_wdata;
   assign WSTRB   = usr_wstrb;

   // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) state <= IDLE;
      else        state <= next_state;
   end

   // NOTE: every output of this block gets a default first, so no path infers a latch.
   always_comb begin
      next_state = state;
      WVALID     = 1'b0;
      WLAST      = 1'b0;
      usr_wready = 1'b0;
      BREADY     = 1'b0;
      case (state)
         IDLE:  if (cmd_accept) next_state = cmd_illegal ? DRAIN : XFER;
         XFER: begin
            if (!w_done) begin
               WVALID     = usr_wvalid;
               usr_wready = WREADY;
               WLAST      = last_beat;
            end
            if (aw_done && w_done) next_state = RESP;
         end
         RESP: begin
            BREADY = 1'b1;
            if (BVALID) next_state = IDLE;
         end
         DRAIN: begin
            usr_wready = 1'b1;
            if (usr_wvalid && last_beat) next_state = IDLE;
         end
         default: next_state = IDLE;
      endcase
   end

   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
         id_q       <= '0;
         addr_q     <= '0;
         len_q      <= '0;
         size_q     <= '0;
         burst_q    <= '0;
         beat_cnt   <= '0;
         aw_done    <= 1'b0;
         w_done     <= 1'b0;
         AWVALID    <= 1'b0;
         usr_bvalid <= 1'b0;
         usr_bid    <= '0;
         usr_bresp  <= '0;
      end else begin
         usr_bvalid <= 1'b0;
         if (cmd_accept) begin
            id_q     <= usr_cmd_id;
            addr_q   <= usr_cmd_addr;
            len_q    <= usr_cmd_len;
            size_q   <= usr_cmd_size;
            burst_q  <= usr_cmd_burst;
            beat_cnt <= '0;
            aw_done  <= 1'b0;
            w_done   <= 1'b0;
            AWVALID  <= !cmd_illegal;
         end
         if (AWVALID && AWREADY) begin
            AWVALID <= 1'b0;
            aw_done <= 1'b1;
         end
         if (WVALID && WREADY) begin
            beat_cnt <= beat_cnt + AXI_LW'(1);
            if (WLAST) w_done <= 1'b1;
         end
         if (state == RESP && BVALID) begin
            usr_bvalid <= 1'b1;
            usr_bid    <= BID;
            usr_bresp  <= (BID != id_q) ? AXI_BRESPW'(RESP_SLVERR) : BRESP;
         end
         // An illegal burst still consumes all of its user beats before answering.
         if (state == DRAIN && usr_wvalid) begin
            beat_cnt <= beat_cnt + AXI_LW'(1);
            if (last_beat) begin
               usr_bvalid <= 1'b1;
               usr_bid    <= id_q;
               usr_bresp  <= AXI_BRESPW'(RESP_SLVERR);
            end
         end
      end
   end

endmodule

// File: tb/tb_ami_w.sv
// Randomized self-checking bench for ami_w against a burst-level reference model.
module tb_ami_w;
   import axi_pkg::*;

   logic         ACLK = 1'b0;
   logic         ARESET;
   logic         usr_cmd_valid, usr_cmd_ready;
   logic [7:0]   usr_cmd_id;
   logic [39:0]  usr_cmd_addr;
   logic [7:0]   usr_cmd_len;
   logic [2:0]   usr_cmd_size;
   logic [1:0]   usr_cmd_burst;
   logic [127:0] usr_wdata;
   logic [15:0]  usr_wstrb;
   logic         usr_wvalid, usr_wready;
   logic         usr_bvalid;
   logic [7:0]   usr_bid;
   logic [1:0]   usr_bresp;
   logic [7:0]   AWID;
   logic [39:0]  AWADDR;
   logic [7:0]   AWLEN;
   logic [2:0]   AWSIZE;
   logic [1:0]   AWBURST;
   logic         AWVALID, AWREADY;
   logic [127:0] WDATA;
   logic [15:0]  WSTRB;
   logic         WLAST, WVALID, WREADY;
   logic [7:0]   BID;
   logic [1:0]   BRESP;
   logic         BVALID, BREADY;

   int n_checks = 0;
   int n_bad    = 0;
   int cmd_no   = 0;

   ami_w dut (
      .ACLK(ACLK), .ARESET(ARESET),
      .usr_cmd_valid(usr_cmd_valid), .usr_cmd_ready(usr_cmd_ready),
      .usr_cmd_id(usr_cmd_id), .usr_cmd_addr(usr_cmd_addr), .usr_cmd_len(usr_cmd_len),
      .usr_cmd_size(usr_cmd_size), .usr_cmd_burst(usr_cmd_burst),
      .usr_wdata(usr_wdata), .usr_wstrb(usr_wstrb), .usr_wvalid(usr_wvalid),
      .usr_wready(usr_wready),
      .usr_bvalid(usr_bvalid), .usr_bid(usr_bid), .usr_bresp(usr_bresp),
      .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
      .AWVALID(AWVALID), .AWREADY(AWREADY),
      .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
      .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY)
   );

   always #5 ACLK = ~ACLK;

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [127:0] beat_data(input int tagn, input int b);
      return {32'(tagn), 32'(b), 32'(tagn * 7 + b), 32'hA5A5_0000 ^ 32'(b)};
   endfunction

   function automatic logic [15:0] beat_strb(input int tagn, input int b);
      return 16'((tagn * 131 + b * 37) ^ 16'h5A5A);
   endfunction

   // Model of the page-crossing rule: bytes moved by an INCR burst must stay in one 4KB page.
   function automatic bit illegal_4kb(input logic [39:0] addr, input int len, input int size,
                                      input logic [1:0] burst);
`ifdef AMI_W_4KB_CHECK_EN
      int bytes;
      bytes = (len + 1) * (1 << size);
      return (burst == BURST_INCR) && (int'(addr[11:0]) + bytes > 4096);
`else
      return 1'b0;
`endif
   endfunction

   task automatic run_cmd(input string tag, input logic [7:0] id, input logic [39:0] addr,
                          input int len, input int size, input logic [1:0] burst,
                          input int wmode, input int aw_after_w, input int aw_delay,
                          input logic [7:0] bid, input logic [1:0] bresp, input int b_delay,
                          input int abort_after);
      int          n, beats, cyc, w_done_cyc, b_wait, tagn;
      bit          drain, aw_hs, b_hs, aw_checked, proto_ok;
      logic [1:0]  exp_resp;
      logic [7:0]  exp_id;
      n          = len + 1;
      drain      = illegal_4kb(addr, len, size, burst);
      exp_resp   = drain ? RESP_SLVERR : ((bid != id) ? RESP_SLVERR : bresp);
      exp_id     = drain ? id : bid;
      beats      = 0;
      w_done_cyc = -1;
      b_wait     = 0;
      aw_hs      = 0;
      b_hs       = 0;
      aw_checked = 0;
      proto_ok   = 1;
      tagn       = ++cmd_no;

      @(negedge ACLK);
      usr_cmd_valid = 1'b1;
      usr_cmd_id    = id;
      usr_cmd_addr  = addr;
      usr_cmd_len   = 8'(len);
      usr_cmd_size  = 3'(size);
      usr_cmd_burst = burst;
      cyc = 0;
      while (!usr_cmd_ready && cyc < 50) begin
         @(negedge ACLK);
         cyc++;
      end
      check($sformatf("%s/cmd_ready", tag), 128'(usr_cmd_ready), 128'(1));
      @(negedge ACLK);
      usr_cmd_valid = 1'b0;

      cyc = 0;
      while (!b_hs && cyc < 2000) begin
         if (aw_after_w >= 0)
            AWREADY = !drain && !aw_hs && (w_done_cyc >= 0) && (cyc >= w_done_cyc + aw_after_w);
         else
            AWREADY = !drain && !aw_hs && (cyc >= aw_delay);
         WREADY = (wmode == 0) ? 1'b1 : (wmode == 1) ? (cyc % 2 == 0) : 1'($urandom % 2);
         if (beats < n) begin
            usr_wvalid = (wmode == 2) ? 1'($urandom % 2) : 1'b1;
            usr_wdata  = beat_data(tagn, beats);
            usr_wstrb  = beat_strb(tagn, beats);
         end else begin
            usr_wvalid = 1'b0;
         end
         BVALID = 1'b0;
         if (!drain && aw_hs && beats == n) begin
            if (b_wait >= b_delay) begin
               BVALID = 1'b1;
               BID    = bid;
               BRESP  = bresp;
            end
            b_wait++;
         end
         #1;
         if (AWVALID && !aw_checked) begin
            aw_checked = 1;
            check($sformatf("%s/awid", tag), 128'(AWID), 128'(id));
            check($sformatf("%s/awaddr", tag), 128'(AWADDR), 128'(addr));
            check($sformatf("%s/awlen", tag), 128'(AWLEN), 128'(len));
            check($sformatf("%s/awsize", tag), 128'(AWSIZE), 128'(size));
            check($sformatf("%s/awburst", tag), 128'(AWBURST), 128'(burst));
         end
         if (drain) begin
            if (AWVALID || WVALID || BREADY) proto_ok = 0;
            if (beats < n && usr_wready !== 1'b1) proto_ok = 0;
            if (usr_wvalid && usr_wready) begin
               beats++;
               if (beats == n) b_hs = 1;
            end
         end else begin
            if (BREADY && !(aw_hs && beats == n)) proto_ok = 0;
            if (beats < n) begin
               if (WVALID !== usr_wvalid || usr_wready !== WREADY) proto_ok = 0;
            end else if (WVALID || usr_wready) begin
               proto_ok = 0;
            end
            if (WVALID && WREADY) begin
               check($sformatf("%s/wdata%0d", tag, beats), WDATA, beat_data(tagn, beats));
               check($sformatf("%s/wstrb%0d", tag, beats), 128'(WSTRB), 128'(beat_strb(tagn, beats)));
               check($sformatf("%s/wlast%0d", tag, beats), 128'(WLAST), 128'(beats == len));
               beats++;
               if (beats == n) w_done_cyc = cyc;
            end
            if (AWVALID && AWREADY) aw_hs = 1;
            if (BVALID && BREADY) b_hs = 1;
         end
         if (abort_after > 0 && beats == abort_after) begin
            @(negedge ACLK);
            #1;
            check($sformatf("%s/awvalid_pre_rst", tag), 128'(AWVALID), 128'(1));
            ARESET = 1'b1;
            #1;
            check($sformatf("%s/rst_awvalid", tag), 128'(AWVALID), 128'(0));
            check($sformatf("%s/rst_wvalid", tag), 128'(WVALID), 128'(0));
            check($sformatf("%s/rst_bready", tag), 128'(BREADY), 128'(0));
            check($sformatf("%s/rst_cmd_ready", tag), 128'(usr_cmd_ready), 128'(0));
            repeat (3) @(negedge ACLK);
            check($sformatf("%s/rst_hold_wvalid", tag), 128'(WVALID), 128'(0));
            ARESET     = 1'b0;
            usr_wvalid = 1'b0;
            AWREADY    = 1'b0;
            WREADY     = 1'b0;
            #1;
            check($sformatf("%s/rel_cmd_ready", tag), 128'(usr_cmd_ready), 128'(1));
            return;
         end
         @(negedge ACLK);
         cyc++;
      end
      check($sformatf("%s/no_timeout", tag), 128'(b_hs), 128'(1));
      BVALID     = 1'b0;
      usr_wvalid = 1'b0;
      AWREADY    = 1'b0;
      #1;
      check($sformatf("%s/protocol", tag), 128'(proto_ok), 128'(1));
      check($sformatf("%s/beats", tag), 128'(beats), 128'(n));
      check($sformatf("%s/aw_issued", tag), 128'(aw_hs), 128'(!drain));
      check($sformatf("%s/bvalid", tag), 128'(usr_bvalid), 128'(1));
      check($sformatf("%s/bid", tag), 128'(usr_bid), 128'(exp_id));
      check($sformatf("%s/bresp", tag), 128'(usr_bresp), 128'(exp_resp));
      @(negedge ACLK);
      #1;
      check($sformatf("%s/bvalid_pulse", tag), 128'(usr_bvalid), 128'(0));
      check($sformatf("%s/idle_ready", tag), 128'(usr_cmd_ready), 128'(1));
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0]  r_id, r_bid;
      logic [39:0] r_addr;
      logic [1:0]  r_burst;
      int          r_len;
      ARESET = 1'b1;
      usr_cmd_valid = 1'b0; usr_cmd_id = '0; usr_cmd_addr = '0; usr_cmd_len = '0;
      usr_cmd_size = '0; usr_cmd_burst = '0; usr_wdata = '0; usr_wstrb = '0;
      usr_wvalid = 1'b0; AWREADY = 1'b0; WREADY = 1'b0;
      BID = '0; BRESP = '0; BVALID = 1'b0;
      #12;
      check("reset/cmd_ready", 128'(usr_cmd_ready), 128'(0));
      check("reset/awvalid", 128'(AWVALID), 128'(0));
      check("reset/wvalid", 128'(WVALID), 128'(0));
      check("reset/bready", 128'(BREADY), 128'(0));
      check("reset/bvalid", 128'(usr_bvalid), 128'(0));
      check("reset/bid", 128'(usr_bid), 128'(0));
      check("reset/bresp", 128'(usr_bresp), 128'(0));
      @(negedge ACLK);
      ARESET = 1'b0;
      #1;
      check("release/cmd_ready", 128'(usr_cmd_ready), 128'(1));

      run_cmd("single", 8'h01, 40'h100, 0, 4, BURST_INCR, 0, -1, 0, 8'h01, RESP_OKAY, 0, 0);
      run_cmd("alt_wready", 8'h02, 40'h2000, 3, 4, BURST_INCR, 1, -1, 0, 8'h02, RESP_OKAY, 1, 0);
      run_cmd("late_aw", 8'h03, 40'h3000, 3, 4, BURST_INCR, 0, 10, 0, 8'h03, RESP_OKAY, 0, 0);
      run_cmd("bid_mismatch", 8'h05, 40'h4000, 1, 4, BURST_INCR, 0, -1, 2, 8'h06, RESP_OKAY, 0, 0);
      run_cmd("cross_4kb", 8'h07, 40'hFF0, 3, 4, BURST_INCR, 0, -1, 0, 8'h07, RESP_OKAY, 0, 0);
      run_cmd("abort", 8'h08, 40'h5000, 7, 4, BURST_INCR, 0, -1, 1000, 8'h08, RESP_OKAY, 0, 2);
      run_cmd("after_abort", 8'h09, 40'h6000, 2, 4, BURST_INCR, 0, -1, 1, 8'h09, RESP_OKAY, 0, 0);

      for (int i = 0; i < 25; i++) begin
         r_id    = 8'($urandom);
         r_addr  = {8'($urandom), 20'($urandom), 12'($urandom_range(2048, 4095))};
         r_len   = ($urandom % 5 == 0) ? 15 : $urandom_range(0, 7);
         case ($urandom % 3)
            0:       r_burst = BURST_FIXED;
            1:       r_burst = BURST_INCR;
            default: r_burst = BURST_WRAP;
         endcase
         r_bid = ($urandom % 4 == 0) ? (r_id ^ 8'h01) : r_id;
         run_cmd($sformatf("rand%0d", i), r_id, r_addr, r_len, $urandom_range(0, 4), r_burst,
                 $urandom_range(0, 2), ($urandom % 3 == 0) ? $urandom_range(0, 4) : -1,
                 $urandom_range(0, 5), r_bid, 2'($urandom), $urandom_range(0, 3), 0);
      end

      $display("test done: total=%0d bad=%0d", n_checks, n_bad);
      $finish;
   end

endmodule
